// File: rtl/uart_frame_tx.sv
// Telemetry frame transmitter: 0xA5 header, NUM_WORDS words LSB-first, 8N1 UART.
// Optional trailing modulo-256 checksum byte when UART_FRAME_CHECKSUM_EN is defined.
module uart_frame_tx #(
    parameter int unsigned NUM_WORDS    = 4,
    parameter int unsigned WORD_BYTES   = 2,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_WORDS*WORD_BYTES*8-1:0] words_in,
    input  logic                              send,
    output logic                              tx,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned PAYLOAD_BYTES = NUM_WORDS * WORD_BYTES;
    localparam int unsigned PW            = PAYLOAD_BYTES * 8;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES   = PAYLOAD_BYTES + 2;
`else
    localparam int unsigned FRAME_BYTES   = PAYLOAD_BYTES + 1;
`endif
    localparam int unsigned IDX_W         = $clog2(FRAME_BYTES);
    localparam int unsigned CNT_W         = $clog2(CLKS_PER_BIT);
    localparam logic [7:0]  HEADER        = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [PW-1:0]      snap_q, snap_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic bit_end;
    logic last_byte;
    logic final_stop_end;

    assign bit_end        = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign last_byte      = (byte_idx_q == IDX_W'(FRAME_BYTES - 1));
    // The final stop period ends one cycle early in STOP so that its last cycle
    // is the done/IDLE cycle; a send there starts the next frame with no gap.
    assign final_stop_end = last_byte && (cnt_q == CNT_W'(CLKS_PER_BIT - 2));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        snap_d     = snap_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        unique case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (send) begin
                    state_d    = START;
                    snap_d     = words_in;
                    shift_d    = HEADER;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
                    csum_d     = HEADER;
`endif
                end
            end

            START: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                end
            end

            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end

            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (final_stop_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end else if (bit_end && !last_byte) begin
                    state_d    = START;
                    cnt_d      = '0;
                    byte_idx_d = byte_idx_q + 1'b1;
                    tx_d       = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
                    if (byte_idx_q == IDX_W'(PAYLOAD_BYTES)) begin
                        shift_d = csum_q;
                    end else begin
                        shift_d = snap_q[7:0];
                        snap_d  = snap_q >> 8;
                        csum_d  = csum_q + snap_q[7:0];
                    end
`else
                    shift_d = snap_q[7:0];
                    snap_d  = snap_q >> 8;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            snap_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
            snap_q     <= snap_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx (NUM_WORDS=2, WORD_BYTES=2, CLKS_PER_BIT=4); expected
// line waveform is derived from the frame byte list, checked every clock.
module tb_uart_frame_tx;

    localparam int NW  = 2;
    localparam int WB  = 2;
    localparam int CPB = 4;
    localparam int PB  = NW * WB;
`ifdef UART_FRAME_CHECKSUM_EN
    localparam int FB  = PB + 2;
`else
    localparam int FB  = PB + 1;
`endif
    localparam int LEN = FB * 10 * CPB;

    logic              clk = 1'b0;
    logic              reset;
    logic              send;
    logic [PB*8-1:0]   words_in;
    logic              tx;
    logic              busy;
    logic              done;

    int unsigned n_pass  = 0;
    int unsigned n_fail  = 0;
    int unsigned n_total = 0;

    logic exp_bits[$];

    uart_frame_tx #(
        .NUM_WORDS   (NW),
        .WORD_BYTES  (WB),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .words_in(words_in),
        .send    (send),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: frame byte list -> one line level per bit period (start, 8 data LSB first, stop).
    task automatic build_model(input logic [PB*8-1:0] w);
        logic [7:0] bytes[$];
        logic [7:0] sum;
        bytes.delete();
        exp_bits.delete();
        bytes.push_back(8'hA5);
        for (int j = 0; j < PB; j++) bytes.push_back(w[j*8 +: 8]);
`ifdef UART_FRAME_CHECKSUM_EN
        sum = 8'h00;
        foreach (bytes[i]) sum = sum + bytes[i];
        bytes.push_back(sum);
`else
        sum = 8'h00;
`endif
        foreach (bytes[i]) begin
            exp_bits.push_back(1'b0);
            for (int b = 0; b < 8; b++) exp_bits.push_back(bytes[i][b]);
            exp_bits.push_back(1'b1);
        end
    endtask

    // Entered just before the accepting clock edge (send already high).
    // Cycle c=1 is the first start-bit cycle; cycle LEN is the done cycle.
    task automatic run_frame(input logic [PB*8-1:0] w, input bit hold, input bit disturb,
                             input logic [PB*8-1:0] next_w, input string tag);
        build_model(w);
        for (int c = 1; c <= LEN; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) send = 1'b0;
            if (c == 2 && hold) words_in = next_w;
            if (disturb && c == 50) begin
                words_in = next_w;
                send     = 1'b1;
            end
            if (disturb && c == 51) send = 1'b0;
            check({tag, " tx"},   {31'd0, tx},   {31'd0, exp_bits[(c-1)/CPB]});
            check({tag, " busy"}, {31'd0, busy}, (c < LEN) ? 32'd1 : 32'd0);
            check({tag, " done"}, {31'd0, done}, (c == LEN) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic idle_check(input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check({tag, " tx"},   {31'd0, tx},   32'd1);
            check({tag, " busy"}, {31'd0, busy}, 32'd0);
            check({tag, " done"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        logic [PB*8-1:0] w;
        logic [PB*8-1:0] w2;
        logic [PB*8-1:0] hw[3];

        reset    = 1'b0;
        send     = 1'b0;
        words_in = '0;
        #2 reset = 1'b1;
        #1;
        check("reset tx",   {31'd0, tx},   32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);

        // send during reset must be ignored
        words_in = 32'h5555_AAAA;
        send     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("send_in_reset busy", {31'd0, busy}, 32'd0);
            check("send_in_reset tx",   {31'd0, tx},   32'd1);
        end
        send = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        idle_check(1000, "idle1000");

        // Fixed vector A5,34,12,CD,AB (+63 checksum)
        @(negedge clk);
        w = 32'hABCD_1234;
        words_in = w;
        send = 1'b1;
        run_frame(w, 1'b0, 1'b0, '0, "fixed");
        idle_check(3, "post_fixed");

        // Mid-frame words_in change and send pulse are ignored
        @(negedge clk);
        words_in = w;
        send = 1'b1;
        run_frame(w, 1'b0, 1'b1, 32'h0000_FFFF, "busy_send");
        idle_check(5, "post_busy_send");

        // Random payloads
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            w = $urandom;
            words_in = w;
            send = 1'b1;
            run_frame(w, 1'b0, 1'b0, '0, "random");
            idle_check(2, "post_random");
        end

        // send held high: back-to-back frames, next payload captured in the done cycle
        for (int k = 0; k < 3; k++) hw[k] = $urandom;
        @(negedge clk);
        words_in = hw[0];
        send = 1'b1;
        for (int k = 0; k < 3; k++) begin
            w2 = (k < 2) ? hw[k+1] : hw[k];
            run_frame(hw[k], 1'b1, 1'b0, w2, "b2b");
        end
        send = 1'b0;
        idle_check(5, "post_b2b");

        // Reset during the third byte's data bits aborts the frame
        @(negedge clk);
        w = $urandom;
        words_in = w;
        send = 1'b1;
        build_model(w);
        for (int c = 1; c < 90; c++) begin
            @(negedge clk);
            if (c == 1) send = 1'b0;
            check("pre_abort tx", {31'd0, tx}, {31'd0, exp_bits[(c-1)/CPB]});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort tx",   {31'd0, tx},   32'd1);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_reset done", {31'd0, done}, 32'd0);
            check("in_reset tx",   {31'd0, tx},   32'd1);
        end
        reset = 1'b0;
        idle_check(20, "post_abort");

        @(negedge clk);
        w = $urandom;
        words_in = w;
        send = 1'b1;
        run_frame(w, 1'b0, 1'b0, '0, "after_abort");
        idle_check(5, "final_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
